// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the multi-port data memory and its arbiter.
package dmem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slice_lo(int index, int width);
    return index * width;
  endfunction

endpackage

// File: rtl/multi_port_data_memory_if.sv
// Packed per-port request/response bus between requesters and the shared data memory.
interface multi_port_data_memory_if #(
  parameter int NUM_PORTS     = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic [NUM_PORTS-1:0]               req;
  logic [NUM_PORTS-1:0]               we;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata;
  logic [NUM_PORTS-1:0]               gnt;
  logic [NUM_PORTS-1:0]               rvalid;
  logic [NUM_PORTS*DATA_WIDTH-1:0]    rdata;
  logic [NUM_PORTS-1:0]               err;
  logic                               init_done;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err, init_done
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err, init_done
  );
endinterface

// File: rtl/multi_port_data_memory_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module round_robin_arbiter
  import dmem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] gnt
);

  localparam int PW = idx_width(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win;
  logic [PW-1:0] idx_k;
  logic          found;
  int            sum;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    sum   = 0;
    idx_k = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= N) sum = sum - N;
      idx_k = PW'(sum);
      if (enable && !found && req[idx_k]) begin
        found      = 1'b1;
        gnt[idx_k] = 1'b1;
        win        = idx_k;
      end
    end
  end

  // Pointer only advances on an actual grant, so an idle cycle keeps priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (int'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/multi_port_data_memory.sv
// Shared word memory serving NUM_PORTS load/store requesters with round-robin access
// and a hardware zero sweep after reset.
module multi_port_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEMORY_SIZE   = 1024,
  parameter int NUM_PORTS     = 2
) (
  input logic                     clk,
  input logic                     reset_n,
  multi_port_data_memory_if.slave bus
);

  localparam int CNT_W  = idx_width(MEMORY_SIZE);
  localparam int PORT_W = idx_width(NUM_PORTS);
  localparam int CMP_W  = ADDRESS_WIDTH + 32;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEMORY_SIZE - 1);

  state_t                          state_q;
  state_t                          state_d;
  logic [CNT_W-1:0]                sweep_cnt;
  logic [DATA_WIDTH-1:0]           mem [MEMORY_SIZE];
  logic [NUM_PORTS-1:0]            gnt_vec;
  logic [NUM_PORTS-1:0]            rvalid_q;
  logic [NUM_PORTS-1:0]            err_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q;
  logic [PORT_W-1:0]               sel;
  logic                            any_gnt;
  logic                            sel_we;
  logic                            sel_in_range;
  logic [ADDRESS_WIDTH-1:0]        sel_addr;
  logic [DATA_WIDTH-1:0]           sel_wdata;
  logic [CNT_W-1:0]                sel_idx;

  round_robin_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req),
    .enable  (state_q == RUN),
    .gnt     (gnt_vec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (sweep_cnt == LAST_IDX) state_d = RUN;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sweep_cnt <= '0;
    end else if (state_q == INIT && sweep_cnt != LAST_IDX) begin
      sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // Only one port can hold the grant, so a single mux feeds the array.
  always_comb begin
    sel     = '0;
    any_gnt = |gnt_vec;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_vec[i]) sel = PORT_W'(i);
    end
  end

  assign sel_we       = bus.we[sel];
  assign sel_addr     = bus.addr[slice_lo(int'(sel), ADDRESS_WIDTH) +: ADDRESS_WIDTH];
  assign sel_wdata    = bus.wdata[slice_lo(int'(sel), DATA_WIDTH) +: DATA_WIDTH];
  assign sel_in_range = CMP_W'(sel_addr) < CMP_W'(MEMORY_SIZE);
  assign sel_idx      = CNT_W'(sel_addr);

  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[sweep_cnt] <= '0;
    end else if (any_gnt && sel_we && sel_in_range) begin
      mem[sel_idx] <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt_vec;
      err_q    <= '0;
      if (any_gnt) begin
        err_q[sel] <= !sel_in_range;
        if (!sel_we) begin
          rdata_q[slice_lo(int'(sel), DATA_WIDTH) +: DATA_WIDTH] <=
            sel_in_range ? mem[sel_idx] : '0;
        end
      end
    end
  end

  assign bus.gnt       = gnt_vec;
  assign bus.rvalid    = rvalid_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.init_done = (state_q == RUN);

endmodule

// File: tb/tb_multi_port_data_memory.sv
// Scoreboard bench for multi_port_data_memory: a 2-port 16-word instance plus a 3-port one.
module tb_multi_port_data_memory;

  localparam int NP = 2;
  localparam int MS = 16;
  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct {
    int              port;
    logic            err;
    logic            is_read;
    logic [DW-1:0]   data;
  } resp_t;

  logic clk;
  logic reset_n;

  multi_port_data_memory_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();
  multi_port_data_memory_if #(.NUM_PORTS(3),  .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus3 ();

  multi_port_data_memory #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEMORY_SIZE(MS), .NUM_PORTS(NP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  multi_port_data_memory #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEMORY_SIZE(MS), .NUM_PORTS(3)
  ) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus3)
  );

  int            assert_count = 0;
  int            fail_count   = 0;
  resp_t         sb[$];
  logic [2:0]    q3[$];
  logic [DW-1:0] mem_model [MS];
  logic [DW-1:0] rdata_model [NP];
  int            ptr_model;
  int            init_cnt;
  int            gnt_count [NP];
  int            multi_gnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int p, input logic r, input logic w,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[p]            = r;
    bus.we[p]             = w;
    bus.addr[p*AW +: AW]  = a;
    bus.wdata[p*DW +: DW] = d;
  endtask

  task automatic idle();
    bus.req = '0;
    bus.we  = '0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check_output("rst_rvalid", bus.rvalid, '0);
    check_output("rst_err", bus.err, '0);
    check_output("rst_gnt", bus.gnt, '0);
    check_output("rst_init_done", bus.init_done, 1'b0);
    check_output("rst_rdata", bus.rdata, '0);
    sb.delete();
    ptr_model = 0;
    init_cnt  = 0;
    for (int p = 0; p < NP; p++) rdata_model[p] = '0;
    for (int a = 0; a < MS; a++) mem_model[a] = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Compare last cycle's responses, then predict this cycle's grant and its response.
  task automatic sample_and_check();
    resp_t          r;
    logic [NP-1:0]  exp_rv;
    logic [NP-1:0]  exp_err;
    logic [NP-1:0]  exp_gnt;
    logic [AW-1:0]  a;
    int             win;
    int             idx;
    exp_rv  = '0;
    exp_err = '0;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      exp_rv[r.port]  = 1'b1;
      exp_err[r.port] = r.err;
      if (r.is_read) rdata_model[r.port] = r.data;
    end
    check_output("rvalid", bus.rvalid, exp_rv);
    check_output("err", bus.err, exp_err);
    for (int p = 0; p < NP; p++)
      check_output($sformatf("rdata%0d", p), bus.rdata[p*DW +: DW], rdata_model[p]);
    check_output("init_done", bus.init_done, init_cnt >= MS);

    exp_gnt = '0;
    win     = -1;
    if (init_cnt >= MS) begin
      for (int k = 0; k < NP; k++) begin
        idx = (ptr_model + k) % NP;
        if (win < 0 && bus.req[idx]) win = idx;
      end
    end
    if (win >= 0) exp_gnt[win] = 1'b1;
    check_output("gnt", bus.gnt, exp_gnt);
    if ($countones(bus.gnt) > 1) multi_gnt++;
    for (int p = 0; p < NP; p++) if (bus.gnt[p]) gnt_count[p]++;

    if (win >= 0) begin
      a         = bus.addr[win*AW +: AW];
      r.port    = win;
      r.err     = (a >= AW'(MS));
      r.is_read = !bus.we[win];
      r.data    = r.err ? '0 : mem_model[a[3:0]];
      if (bus.we[win] && !r.err) mem_model[a[3:0]] = bus.wdata[win*DW +: DW];
      sb.push_back(r);
      ptr_model = (win + 1) % NP;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    if (reset_n && init_cnt < MS) init_cnt++;
    #1;
  endtask

  task automatic readback_all(input int p);
    for (int a = 0; a < MS; a++) begin
      apply_stimulus(p, 1'b1, 1'b0, AW'(a), '0);
      step();
    end
    idle();
    step();
  endtask

  initial begin
    logic [2:0] exp_rv3;
    reset_n    = 1'b1;
    bus.req    = '0;
    bus.we     = '0;
    bus.addr   = '0;
    bus.wdata  = '0;
    bus3.req   = '0;
    bus3.we    = '0;
    bus3.addr  = '0;
    bus3.wdata = '0;
    multi_gnt  = 0;
    for (int p = 0; p < NP; p++) gnt_count[p] = 0;

    @(posedge clk);
    #1;
    apply_reset();

    // Sweep with both ports requesting: no grants, init_done after 16 edges.
    apply_stimulus(0, 1'b1, 1'b0, 32'd3, '0);
    apply_stimulus(1, 1'b1, 1'b0, 32'd7, '0);
    repeat (MS) step();
    idle();
    step();
    readback_all(0);

    apply_stimulus(0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
    step();
    idle();
    apply_stimulus(1, 1'b1, 1'b0, 32'd5, '0);
    step();
    idle();
    step();

    // Continuous contention: alternating grants, four each.
    for (int p = 0; p < NP; p++) gnt_count[p] = 0;
    multi_gnt = 0;
    apply_stimulus(0, 1'b1, 1'b1, 32'd9, 32'h12345678);
    apply_stimulus(1, 1'b1, 1'b0, 32'd9, '0);
    repeat (8) step();
    idle();
    step();
    check_output("gnt_count0", 64'(gnt_count[0]), 64'd4);
    check_output("gnt_count1", 64'(gnt_count[1]), 64'd4);
    check_output("multi_gnt", 64'(multi_gnt), 64'd0);

    // Out-of-range accesses leave the array untouched.
    apply_stimulus(1, 1'b1, 1'b0, 32'd16, '0);
    step();
    idle();
    apply_stimulus(0, 1'b1, 1'b1, 32'd20, 32'hBAD0BAD0);
    step();
    idle();
    apply_stimulus(1, 1'b1, 1'b1, 32'h80000005, 32'hCAFEF00D);
    step();
    idle();
    readback_all(1);

    // Reset in the cycle after a granted (erroring) read.
    apply_stimulus(0, 1'b1, 1'b0, 32'd16, '0);
    step();
    idle();
    apply_reset();
    repeat (MS) step();
    apply_stimulus(0, 1'b1, 1'b0, 32'd5, '0);
    apply_stimulus(1, 1'b1, 1'b0, 32'd9, '0);
    step();
    step();
    idle();
    step();

    // Reset in the middle of the sweep, at counter 7.
    apply_reset();
    repeat (7) step();
    apply_reset();
    repeat (MS) step();
    step();
    readback_all(0);

    // Three-port instance, only port 2 requesting.
    bus3.req                = 3'b100;
    bus3.we                 = 3'b000;
    bus3.addr[2*AW +: AW]   = 32'd4;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus3.req = 3'b000;
      @(negedge clk);
      exp_rv3 = (q3.size() > 0) ? q3.pop_front() : 3'b000;
      check_output("np3_rvalid", bus3.rvalid, exp_rv3);
      check_output("np3_err", bus3.err, 3'b000);
      check_output("np3_gnt", bus3.gnt, (k < 3) ? 3'b100 : 3'b000);
      if (k < 3) q3.push_back(3'b100);
      @(posedge clk);
      #1;
    end
    check_output("np3_rdata2", bus3.rdata[2*DW +: DW], '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/multi_port_data_memory.md
Name: multi_port_data_memory

Overview:
- Parametrised successor to the single-port data memory used by the CGRA simulator.
- Serves NUM_PORTS independent load/store requesters, for example several memory-access PEs, from one shared word array.
- Round-robin arbitration, per-port grant and read-valid handshakes, out-of-range error reporting.
- Hardware zero-initialisation sweep after reset replaces the bulk reset loop.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDRESS_WIDTH, 32, width of each port address.
- MEMORY_SIZE, 1024, number of words; need not be a power of two.
- NUM_PORTS, 2, number of requester ports, minimum 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_PORTS  per-port request.
- we  input  NUM_PORTS  per-port write (1) or read (0).
- addr  input  NUM_PORTS*ADDRESS_WIDTH  packed word addresses; port i occupies slice i.
- wdata  input  NUM_PORTS*DATA_WIDTH  packed write data.
- gnt  output  NUM_PORTS  request accepted at this edge; combinational.
- rvalid  output  NUM_PORTS  one-cycle pulse: response for port i.
- rdata  output  NUM_PORTS*DATA_WIDTH  packed read data.
- err  output  NUM_PORTS  one-cycle pulse alongside rvalid for an out-of-range access.
- init_done  output  1  high once the zero sweep completes.

Behaviour:
- Reset (asynchronous, any time, including mid-sweep or mid-access):
  - state=INIT, sweep counter=0, round-robin pointer=port 0.
  - rvalid=0, err=0, rdata=0, init_done=0, gnt=0.
  - Pending responses are discarded.
- INIT:
  - Each cycle writes 0 to mem[counter], then counter+1.
  - On the edge writing index MEMORY_SIZE-1: state goes to RUN and init_done goes to 1.
  - Sweep takes exactly MEMORY_SIZE cycles.
  - gnt is held 0; req is ignored.
- RUN:
  - At most one gnt bit per cycle.
  - The winner is the first requesting port at or after the pointer, wrapping modulo NUM_PORTS.
  - On a grant, the pointer moves to winner+1 (mod NUM_PORTS); with no request it is unchanged.
  - Requesters hold req/we/addr/wdata stable until gnt is seen high, then may change the next cycle.
  - Granted write, in range: mem[addr] <= wdata at that edge; rvalid pulses for the port next cycle; rdata unchanged.
  - Granted read, in range: rdata slice i = mem[addr] and rvalid[i]=1 in the next cycle (latency 1). The slice holds its value until the next read response on that port.
  - Read of an address written at an earlier edge returns the new data.
  - Out of range (addr >= MEMORY_SIZE): no memory update; rvalid and err both pulse next cycle; rdata slice = 0 for reads.
- Back-to-back grants to the same port on consecutive cycles are legal and give consecutive rvalid pulses.
- Ungranted ports get no rvalid or err.
- init_done stays 1 until the next reset.

Decomposition:
- Package dmem_pkg:
  - state enum {INIT, RUN}.
  - localparams: sweep counter width $clog2(MEMORY_SIZE), port index width $clog2(NUM_PORTS) (minimum 1).
  - Helper function for slice extraction.
- Sub-module round_robin_arbiter, parameter N:
  - Inputs: req, enable, clk, reset_n.
  - Outputs: one-hot gnt; owns the pointer register.
  - Reusable by other shared-resource blocks.

Test Plan:
- Reset release, MEMORY_SIZE=16 -> init_done rises after exactly 16 cycles; gnt stays 0 throughout despite req=11; later reads of all 16 addresses return 0.
- Port 0 writes 0xDEADBEEF to addr 5, then port 1 reads addr 5 -> port 1 sees rvalid with rdata 0xDEADBEEF one cycle after its grant; err=0.
- Both ports request continuously, 8 cycles -> grants alternate 0,1,0,1…; exactly four grants each; never two gnt bits in one cycle.
- Port 1 reads addr 16 with MEMORY_SIZE=16 -> rvalid[1] and err[1] pulse next cycle with rdata 0; a write to addr 20 leaves memory unchanged on full readback.
- reset_n dropped mid-sweep at counter=7, and separately in the cycle after a read grant -> rvalid and err are 0 immediately, the sweep restarts from 0, and the pointer returns to port 0.
- NUM_PORTS=3, only port 2 requests, 3 cycles -> gnt=100 every cycle; rvalid[2] pulses on 3 consecutive cycles.
